// File: rtl/divider_pkg.sv
// Shared constants and state encoding for the multi-cycle MIPS DIV/DIVU unit.
// Combinational only; no timing or flow-control behaviour of its own.
package divider_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 6;

  // ALU control codes decoded in the datapath into start/signed_div
  localparam logic [4:0] DIV_CONTROL  = 5'b11010;
  localparam logic [4:0] DIVU_CONTROL = 5'b11011;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_ON     = 2'b01,
    DIV_BYZERO = 2'b10,
    DIV_END    = 2'b11
  } div_state_t;

endpackage

// File: rtl/divider.sv
// Radix-2 restoring divider: remainder to hi_out, quotient to lo_out; 34 cycles start->ready (2 for /0).
// No backpressure: busy stalls the pipeline, start is ignored unless idle, annul abandons the operation.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_div,
  input  logic             start,
  input  logic             annul,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  div_state_t         r_state;
  logic [2*WIDTH:0]   r_pr;
  logic [WIDTH-1:0]   r_dvsr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg_q;
  logic               r_neg_r;

  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH:0]   w_shift;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH:0]   w_step;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_neg_a = signed_div & a[WIDTH-1];
  assign w_neg_b = signed_div & b[WIDTH-1];
  assign w_a_mag = w_neg_a ? (~a + 1'b1) : a;
  assign w_b_mag = w_neg_b ? (~b + 1'b1) : b;

  // Upper 33 bits hold the partial remainder, lower 32 the dividend/quotient
  assign w_shift = r_pr << 1;
  assign w_trial = w_shift[2*WIDTH:WIDTH] - {1'b0, r_dvsr};
  assign w_step  = w_trial[WIDTH] ? w_shift : {w_trial, w_shift[WIDTH-1:1], 1'b1};

  assign w_quot     = r_pr[WIDTH-1:0];
  assign w_rem      = r_pr[2*WIDTH-1:WIDTH];
  assign w_quot_fix = r_neg_q ? (~w_quot + 1'b1) : w_quot;
  assign w_rem_fix  = r_neg_r ? (~w_rem + 1'b1) : w_rem;

  // Results and ready are registered on the edge that enters END, so ready is visible during END
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_FREE;
      r_pr    <= '0;
      r_dvsr  <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b0;
      hi_out  <= '0;
      lo_out  <= '0;
    end else if (annul) begin
      r_state <= DIV_FREE;
      busy    <= 1'b0;
      ready   <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (r_state)
        DIV_FREE: begin
          if (start) begin
            r_dvsr  <= w_b_mag;
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
            r_pr    <= {{(WIDTH+1){1'b0}}, w_a_mag};
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= (b == '0) ? DIV_BYZERO : DIV_ON;
          end
        end
        DIV_ON: begin
          if (r_cnt == CNT_W'(DIV_ITERS)) begin
            hi_out  <= w_rem_fix;
            lo_out  <= w_quot_fix;
            ready   <= 1'b1;
            r_state <= DIV_END;
          end else begin
            r_pr  <= w_step;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DIV_BYZERO: begin
          hi_out  <= '0;
          lo_out  <= '0;
          ready   <= 1'b1;
          r_state <= DIV_END;
        end
        DIV_END: begin
          busy    <= 1'b0;
          r_state <= DIV_FREE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= DIV_FREE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed plus randomized checks of divider against a plain-arithmetic reference model.
module tb_divider;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        signed_div;
  logic        start;
  logic        annul;
  logic        busy;
  logic        ready;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int total;
  int bad;
  logic [31:0] prev_q;
  logic [31:0] prev_r;

  divider dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .signed_div (signed_div),
    .start      (start),
    .annul      (annul),
    .busy       (busy),
    .ready      (ready),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // MIPS semantics: truncating division, remainder takes the dividend's sign
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic ms,
                       output logic [31:0] q, output logic [31:0] r);
    int sa;
    int sb;
    if (mb == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else if (!ms) begin
      q = ma / mb;
      r = ma % mb;
    end else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = ma;
      sb = mb;
      q = sa / sb;
      r = sa % sb;
    end
  endtask

  task automatic run_div(input logic [31:0] ta, input logic [31:0] tbv, input logic ts, input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    int lat;
    int cyc;
    int nbusy;
    model(ta, tbv, ts, eq, er);
    lat = (tbv == 32'd0) ? 2 : 34;
    a = ta;
    b = tbv;
    signed_div = ts;
    start = 1'b1;
    cyc = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      signed_div = 1'($urandom);
      cyc++;
      if (busy) nbusy++;
    end while (!ready && cyc < 100);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    check({tag, "_lo"}, lo_out, eq);
    check({tag, "_hi"}, hi_out, er);
    check({tag, "_busycycles"}, 32'(nbusy), 32'(lat));
    @(negedge clk);
    check({tag, "_ready_pulse"}, 32'(ready), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_lo_hold"}, lo_out, eq);
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    int pulses;
    int sel;
    logic [31:0] ra;
    logic [31:0] rb;
    total = 0;
    bad = 0;
    rst = 1'b1;
    a = '0;
    b = '0;
    signed_div = 1'b0;
    start = 1'b0;
    annul = 1'b0;
    prev_q = '0;
    prev_r = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);

    run_div(32'd100, 32'd7, 1'b0, "divu_100_7");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, "divu_m7_2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
    run_div(32'd5, 32'd0, 1'b1, "div_by0");
    run_div(32'd9, 32'd3, 1'b1, "div_9_3");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, "div_7_m2");

    // annul mid-divide: no ready, outputs keep the previous result
    a = 32'd1000;
    b = 32'd10;
    signed_div = 1'b0;
    start = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (ready) pulses++;
      if (i == 10) annul = 1'b1;
    end
    @(negedge clk);
    annul = 1'b0;
    check("annul_busy", 32'(busy), 32'd0);
    check("annul_ready", 32'(ready), 32'd0);
    check("annul_lo_hold", lo_out, prev_q);
    check("annul_hi_hold", hi_out, prev_r);
    repeat (40) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    check("annul_no_pulse", 32'(pulses), 32'd0);

    // start together with annul is dropped
    a = 32'd50;
    b = 32'd5;
    start = 1'b1;
    annul = 1'b1;
    @(negedge clk);
    start = 1'b0;
    annul = 1'b0;
    check("start_annul_busy", 32'(busy), 32'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready || busy) pulses++;
    end
    check("start_annul_quiet", 32'(pulses), 32'd0);

    // synchronous reset mid-divide
    a = 32'd1000;
    b = 32'd10;
    signed_div = 1'b0;
    start = 1'b1;
    repeat (20) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_hi", hi_out, 32'd0);
    check("midrst_lo", lo_out, 32'd0);
    run_div(32'hFFFF_FFFF, 32'h10, 1'b0, "divu_ffff_16");

    for (int n = 0; n < 24; n++) begin
      sel = int'($urandom_range(5, 0));
      ra = $urandom;
      case (sel)
        0: rb = 32'd0;
        1: rb = $urandom_range(15, 1);
        2: rb = 32'hFFFF_FFFF - $urandom_range(15, 0);
        3: rb = 32'd1;
        default: rb = $urandom;
      endcase
      if (sel == 4) ra = 32'h8000_0000;
      run_div(ra, rb, 1'($urandom), $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divider.md
# divider

Multi-cycle 32-bit integer divider for the execute stage, alongside the ALU. Implements MIPS DIV and DIVU: it takes rs/rt when the decoded ALU control is a divide code, iterates one quotient bit per cycle, and delivers the remainder to HI and the quotient to LO. The HI/LO write-back path consumes the result. The hazard unit holds the pipeline while the divider is busy.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- a  in  32  dividend (rs value).
- b  in  32  divisor (rt value).
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU.
- start  in  1  request a divide; sampled only in IDLE.
- annul  in  1  flush or exception; abandons any operation.
- busy  out  1  high whenever state != IDLE; drives pipeline stall.
- ready  out  1  one-cycle pulse; result valid.
- hi_out  out  32  remainder.
- lo_out  out  32  quotient.

## Operation
- States:
  - IDLE, ON, DIV_ZERO, END.
  - Encodings are 2 bits.
- Reset forces IDLE and sets busy=0, ready=0, hi_out=0, lo_out=0. This applies in any state, including mid-divide.
- IDLE:
  - start=1 and annul=0 latches a, b and signed_div.
  - Goes to DIV_ZERO if b==0, else to ON with the iteration counter at 0.
  - start while not IDLE is ignored.
- Signed setup:
  - The absolute values of the operands are latched.
  - Quotient sign is a[31]^b[31]; remainder sign is a[31].
  - Unsigned mode uses the raw operands.
- ON:
  - Radix-2 restoring step each cycle on a 65-bit partial-remainder/quotient register.
  - Shift left 1, trial-subtract the divisor from the upper half.
  - If the result is non-negative, keep it and set quotient bit 1; otherwise keep the shifted value and set bit 0.
  - After 32 steps, go to END.
- END:
  - Apply the sign fixups with two's-complement negation modulo 2^32.
  - Load hi_out/lo_out and assert ready for this cycle only.
  - Go to IDLE.
- DIV_ZERO: one cycle, then END with hi_out=0 and lo_out=0.
- Overflow, 0x80000000 / 0xFFFFFFFF signed: lo_out=0x80000000, hi_out=0. No exception is raised.
- annul=1 in any state:
  - Next state is IDLE and ready stays 0.
  - hi_out/lo_out keep their previous values.
  - annul wins over a simultaneous start.
- hi_out/lo_out hold their last result until the next END. They are unaffected by operand changes after the start cycle.

## Timing
- All outputs are registered.
- Start sampled at edge k (non-zero divisor):
  - busy=1 from after edge k.
  - ON steps occur at edges k+1..k+32.
  - END is entered at edge k+33; ready=1 and results are valid in the cycle after edge k+33.
  - IDLE at edge k+34, and busy=0 from then.
  - Total latency: 34 cycles from start to ready.
- Divide by zero: DIV_ZERO after edge k, END after k+1. ready is high in the cycle after edge k+1; latency 2.
- Back-to-back: a new start is accepted in the first IDLE cycle, i.e. the cycle after ready.
- busy drops in the cycle after an annul edge.

## Structure
- Add to defines2.vh:
  - DIV_CONTROL and DIVU_CONTROL ALU control codes, distinct from the existing 5-bit codes.
  - State encodings DIV_FREE/DIV_ON/DIV_BYZERO/DIV_END.
  - The iteration count constant, 32.
- Single module; no sub-module. The negate helper is an inline expression.
- Decode of DIV_CONTROL/DIVU_CONTROL into start/signed_div is done in the datapath, outside this block.

## Test plan
- DIVU, a=100, b=7, start pulse -> lo_out=14, hi_out=2. ready is high exactly 34 cycles after start, and busy is high for 34 cycles.
- DIV, a=0xFFFFFFF9 (-7), b=2 -> lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1). DIVU with the same operands -> lo_out=0x7FFFFFFC, hi_out=1.
- DIV, a=0x80000000, b=0xFFFFFFFF -> lo_out=0x80000000, hi_out=0, no hang.
- a=5, b=0 -> ready 2 cycles after start, hi_out=0, lo_out=0. A subsequent 9/3 gives lo_out=3, hi_out=0.
- Start 1000/10 with annul at cycle 10 -> no ready pulse, busy=0 at cycle 11, and the outputs retain the previous result. A start asserted together with annul is ignored.
- rst at cycle 20 of a divide -> busy=0, ready=0, hi_out=lo_out=0 next cycle. Then 0xFFFFFFFF/0x10 DIVU -> lo_out=0x0FFFFFFF, hi_out=0xF.
